addsub_arb: RTL

- Two-requester arbiter and sequencer sharing one 8-bit add/sub datapath (addsub_st).
- Accepts operand/opcode transactions over valid/ready, drives the datapath's S3/S2 select, registers result and Z/C/O flags, and returns them to the winning requester over a response handshake.
- Sits between ALU-issuing controllers and the add/sub unit inside the top ALU.

---
 rtl/addsub_arb_pkg.sv | 23 ++
 rtl/addsub_st.sv | 38 +++
 rtl/addsub_arb.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/addsub_arb_pkg.sv
// Shared opcodes, FSM state encoding and requester indices for the add/sub arbiter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package addsub_arb_pkg;

   // Opcode encoding; the two bits drive the datapath S3/S2 selects directly
   localparam logic [1:0] OP_ADD  = 2'b00;
   localparam logic [1:0] OP_SUB  = 2'b01;
   localparam logic [1:0] OP_SUB2 = 2'b10;
   localparam logic [1:0] OP_NEG  = 2'b11;

   // Sequencer states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   // Requester indices
   localparam logic REQ0 = 1'b0;
   localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/addsub_st.sv
// 8-bit add/sub datapath: ADD a+b, SUB a+~b+1, NEG 0+~b+1, with Z/C/O flags.
// Latency: purely combinational.
// Backpressure: none; the caller registers inputs and outputs.
module addsub_st
   import addsub_arb_pkg::*;
(
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       s3,
   input  logic       s2,
   output logic [7:0] s,
   output logic       z,
   output logic       c,
   output logic       o
);

   logic       neg;
   logic       inv;
   logic [7:0] x;
   logic [7:0] y;
   logic [7:0] lo;
   logic [1:0] hi;

   // Split the sum at bit 7 so the carry into the MSB is visible for overflow
   always_comb begin
      neg = ({s3, s2} == OP_NEG);
      inv = ({s3, s2} != OP_ADD);
      x   = neg ? 8'h00 : a;
      y   = inv ? ~b : b;
      lo  = {1'b0, x[6:0]} + {1'b0, y[6:0]} + {7'd0, inv};
      hi  = {1'b0, x[7]} + {1'b0, y[7]} + {1'b0, lo[7]};
      s   = {hi[0], lo[6:0]};
      c   = hi[1];
      o   = hi[1] ^ lo[7];
      z   = (s == 8'h00);
   end

endmodule

// File: rtl/addsub_arb.sv
// Two-requester arbiter/sequencer around one shared add/sub datapath.
// Latency: accept in cycle T, response valid from T+2; one operation per 3 cycles at best.
// Backpressure: requests held off outside IDLE; response held stable until the owner takes it.
module addsub_arb
   import addsub_arb_pkg::*;
#(
   parameter bit FIXED_PRIO = 1'b0,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [1:0]       req0_op,
   input  logic [7:0]       req0_a,
   input  logic [7:0]       req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [1:0]       req1_op,
   input  logic [7:0]       req1_a,
   input  logic [7:0]       req1_b,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [7:0]       rsp_result,
   output logic             rsp_z,
   output logic             rsp_c,
   output logic             rsp_o,
   output logic             busy,
   output logic [CNT_W-1:0] op_count
);

   state_t           state_q;
   state_t           state_d;
   logic             grant;
   logic             accept;
   logic             rsp_hs;
   logic             owner_q;
   logic             last_q;
   logic [1:0]       op_q;
   logic [7:0]       a_q;
   logic [7:0]       b_q;
   logic [7:0]       result_q;
   logic             z_q;
   logic             c_q;
   logic             o_q;
   logic [CNT_W-1:0] cnt_q;
   logic [7:0]       dp_s;
   logic             dp_z;
   logic             dp_c;
   logic             dp_o;

   addsub_st u_dp (
      .a  (a_q),
      .b  (b_q),
      .s3 (op_q[1]),
      .s2 (op_q[0]),
      .s  (dp_s),
      .z  (dp_z),
      .c  (dp_c),
      .o  (dp_o)
   );

   // Arbitration: a lone requester wins; on a tie pick per priority mode
   always_comb begin
      grant = REQ0;
      if (req0_valid && req1_valid) begin
         grant = FIXED_PRIO ? REQ0 : ~last_q;
      end else if (req1_valid) begin
         grant = REQ1;
      end
      req0_ready = (state_q == IDLE) && (grant == REQ0) && req0_valid;
      req1_ready = (state_q == IDLE) && (grant == REQ1) && req1_valid;
      accept     = req0_ready || req1_ready;
   end

   // Next-state logic and response-side outputs
   always_comb begin
      state_d    = state_q;
      rsp0_valid = 1'b0;
      rsp1_valid = 1'b0;
      rsp_hs     = 1'b0;
      case (state_q)
         IDLE: if (accept) state_d = EXEC;
         EXEC: state_d = RESP;
         RESP: begin
            rsp0_valid = (owner_q == REQ0);
            rsp1_valid = (owner_q == REQ1);
            rsp_hs     = (owner_q == REQ0) ? rsp0_ready : rsp1_ready;
            if (rsp_hs) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Result and flags only appear on the bus while a response is offered
   always_comb begin
      rsp_result = (state_q == RESP) ? result_q : 8'h00;
      rsp_z      = (state_q == RESP) && z_q;
      rsp_c      = (state_q == RESP) && c_q;
      rsp_o      = (state_q == RESP) && o_q;
      busy       = (state_q != IDLE);
      op_count   = cnt_q;
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Operand capture, result capture, fairness history and completion count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner_q  <= REQ0;
         last_q   <= REQ1;
         op_q     <= 2'b00;
         a_q      <= 8'h00;
         b_q      <= 8'h00;
         result_q <= 8'h00;
         z_q      <= 1'b0;
         c_q      <= 1'b0;
         o_q      <= 1'b0;
         cnt_q    <= '0;
      end else begin
         if (accept) begin
            owner_q <= grant;
            op_q    <= (grant == REQ1) ? req1_op : req0_op;
            a_q     <= (grant == REQ1) ? req1_a  : req0_a;
            b_q     <= (grant == REQ1) ? req1_b  : req0_b;
         end
         if (state_q == EXEC) begin
            result_q <= dp_s;
            z_q      <= dp_z;
            c_q      <= dp_c;
            o_q      <= dp_o;
         end
         if (rsp_hs) begin
            last_q <= owner_q;
            if (cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + 1'b1;
         end
      end
   end

endmodule
